pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Handshake and branch-control bundle between an instruction front end and pc_sequencer.
// The master drives fetch control and branch fields; the slave returns PC, LR, CTR and FSM status.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int LI_W   = 24,
  parameter int BD_W   = 14,
  parameter int CTR_W  = 64
);
  logic              start;
  logic              stall;
  logic [5:0]        opcode;
  logic [LI_W-1:0]   li;
  logic [BD_W-1:0]   bd;
  logic              aa;
  logic              lk;
  logic [4:0]        bo;
  logic              cond_true;
  logic              ctr_load;
  logic [CTR_W-1:0]  ctr_wdata;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic [ADDR_W-1:0] lr;
  logic [CTR_W-1:0]  ctr;
  logic              redirect;
  logic [1:0]        state;

  modport master (
    output start, stall, opcode, li, bd, aa, lk, bo, cond_true, ctr_load, ctr_wdata,
    input  pc, pc_valid, lr, ctr, redirect, state
  );

  modport slave (
    input  start, stall, opcode, li, bd, aa, lk, bo, cond_true, ctr_load, ctr_wdata,
    output pc, pc_valid, lr, ctr, redirect, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with I-form (b) and B-form (bc) branches, link and count registers.
// Taken branches always spend one FLUSH cycle with redirect asserted before fetching resumes.
module pc_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter int                LI_W     = 24,
  parameter int                BD_W     = 14,
  parameter int                CTR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            clock,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_lr;
  logic [CTR_W-1:0]  r_ctr;
  logic              r_redirect;
  logic              r_pcValid;

  logic signed [LI_W-1:0] w_li;
  logic signed [BD_W-1:0] w_bd;
  logic [ADDR_W-1:0]      w_liExt;
  logic [ADDR_W-1:0]      w_bdExt;
  logic [ADDR_W-1:0]      w_pcInc;
  logic [ADDR_W-1:0]      w_target;
  logic [CTR_W-1:0]       w_ctrDec;
  logic                   w_isB;
  logic                   w_isBc;
  logic                   w_ctrOk;
  logic                   w_condOk;
  logic                   w_taken;

  // Size casts of signed values sign-extend when widening and truncate when narrowing,
  // which keeps displacement arithmetic modulo 2^ADDR_W for any width combination.
  assign w_li     = bus.li;
  assign w_bd     = bus.bd;
  assign w_liExt  = ADDR_W'(w_li);
  assign w_bdExt  = ADDR_W'(w_bd);
  assign w_pcInc  = r_pc + ADDR_W'(1);
  assign w_isB    = (bus.opcode == 6'd18);
  assign w_isBc   = (bus.opcode == 6'd19);
  assign w_target = w_isB ? (bus.aa ? w_liExt : w_pcInc + w_liExt)
                          : (bus.aa ? w_bdExt : w_pcInc + w_bdExt);
  assign w_ctrDec = r_ctr - CTR_W'(1);
  assign w_ctrOk  = bus.bo[2] | ((w_ctrDec != '0) ^ bus.bo[1]);
  assign w_condOk = bus.bo[4] | (bus.cond_true == bus.bo[3]);
  assign w_taken  = w_isB | (w_isBc & w_ctrOk & w_condOk);

  // ctr_load is applied last so it overrides the bc decrement in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_lr       <= '0;
      r_ctr      <= '0;
      r_redirect <= 1'b0;
      r_pcValid  <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        IDLE: begin
          r_pc <= RESET_PC;
          if (bus.start) begin
            r_state   <= RUN;
            r_pcValid <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stall) begin
            r_state   <= STALL;
            r_pcValid <= 1'b0;
          end else begin
            if ((w_isB || w_isBc) && bus.lk) r_lr <= w_pcInc;
            if (w_isBc && !bus.bo[2]) r_ctr <= w_ctrDec;
            if (w_taken) begin
              r_pc       <= w_target;
              r_state    <= FLUSH;
              r_redirect <= 1'b1;
              r_pcValid  <= 1'b0;
            end else begin
              r_pc <= w_pcInc;
            end
          end
        end
        STALL: begin
          if (!bus.stall) begin
            r_state   <= RUN;
            r_pcValid <= 1'b1;
          end
        end
        FLUSH: begin
          r_state   <= RUN;
          r_pcValid <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_pcValid <= 1'b0;
        end
      endcase
      if (bus.ctr_load) r_ctr <= bus.ctr_wdata;
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pc_valid = r_pcValid;
  assign bus.lr       = r_lr;
  assign bus.ctr      = r_ctr;
  assign bus.redirect = r_redirect;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle-by-cycle vector table on a default-width instance,
// plus a hand-written wrap-around sequence on an 8-bit-address instance.
module tb_pc_sequencer;

  logic clock;
  logic reset;
  logic reset8;

  pc_sequencer_if #(.ADDR_W(32), .LI_W(24), .BD_W(14), .CTR_W(64)) bus ();
  pc_sequencer_if #(.ADDR_W(8),  .LI_W(24), .BD_W(14), .CTR_W(64)) bus8 ();

  pc_sequencer #(.ADDR_W(32), .LI_W(24), .BD_W(14), .CTR_W(64), .RESET_PC(32'd0)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  pc_sequencer #(.ADDR_W(8), .LI_W(24), .BD_W(14), .CTR_W(64), .RESET_PC(8'd0)) u_dut8 (
    .clock (clock),
    .reset (reset8),
    .bus   (bus8.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        stall;
    logic [5:0]  opcode;
    logic [23:0] li;
    logic [13:0] bd;
    logic        aa;
    logic        lk;
    logic [4:0]  bo;
    logic        condTrue;
    logic        ctrLoad;
    logic [63:0] ctrWdata;
    logic [1:0]  expState;
    logic [31:0] expPc;
    logic        expValid;
    logic [31:0] expLr;
    logic [63:0] expCtr;
    logic        expRedirect;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nBad    = 0;

  function automatic void addVec(
    input string n, input logic rst, input logic st, input logic stl, input logic [5:0] op,
    input logic [23:0] li, input logic [13:0] bd, input logic aa, input logic lk,
    input logic [4:0] bo, input logic ct, input logic ld, input logic [63:0] wd,
    input logic [1:0] eS, input logic [31:0] eP, input logic eV, input logic [31:0] eL,
    input logic [63:0] eC, input logic eR);
    vec_t v;
    v.name = n; v.rst = rst; v.start = st; v.stall = stl; v.opcode = op; v.li = li; v.bd = bd;
    v.aa = aa; v.lk = lk; v.bo = bo; v.condTrue = ct; v.ctrLoad = ld; v.ctrWdata = wd;
    v.expState = eS; v.expPc = eP; v.expValid = eV; v.expLr = eL; v.expCtr = eC; v.expRedirect = eR;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    bus.start     = v.start;
    bus.stall     = v.stall;
    bus.opcode    = v.opcode;
    bus.li        = v.li;
    bus.bd        = v.bd;
    bus.aa        = v.aa;
    bus.lk        = v.lk;
    bus.bo        = v.bo;
    bus.cond_true = v.condTrue;
    bus.ctr_load  = v.ctrLoad;
    bus.ctr_wdata = v.ctrWdata;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    // name, rst, start, stall, op, li, bd, aa, lk, bo, cond, ld, wdata | state, pc, valid, lr, ctr, redirect
    addVec("reset_overrides",  1,1,1, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 1,64'd99, 2'd0, 32'd0, 0, 32'd0, 64'd0, 0);
    addVec("idle_hold",        0,0,0, 6'd18, 24'd5,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd0, 32'd0, 0, 32'd0, 64'd0, 0);
    addVec("start",            0,1,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd0, 1, 32'd0, 64'd0, 0);
    addVec("seq1",             0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd1, 1, 32'd0, 64'd0, 0);
    addVec("seq2",             0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd2, 1, 32'd0, 64'd0, 0);
    addVec("seq3",             0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd3, 1, 32'd0, 64'd0, 0);
    addVec("b_abs10",          0,0,0, 6'd18, 24'd10,      14'd0,     1,0, 5'b00000,0, 0,64'd0,  2'd3, 32'd10,0, 32'd0, 64'd0, 1);
    addVec("flush_ignores",    0,0,1, 6'd18, 24'd100,     14'd0,     1,1, 5'b00000,0, 0,64'd0,  2'd1, 32'd10,1, 32'd0, 64'd0, 0);
    addVec("b_rel_lk",         0,0,0, 6'd18, 24'hFFFFFC,  14'd0,     0,1, 5'b00000,0, 0,64'd0,  2'd3, 32'd7, 0, 32'd11,64'd0, 1);
    addVec("b_rel_flush",      0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd7, 1, 32'd11,64'd0, 0);
    addVec("self_loop",        0,0,0, 6'd18, 24'hFFFFFF,  14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd3, 32'd7, 0, 32'd11,64'd0, 1);
    addVec("self_loop_flush",  0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd7, 1, 32'd11,64'd0, 0);
    addVec("b_abs20_ctr_ld",   0,0,0, 6'd18, 24'd20,      14'd0,     1,0, 5'b00000,0, 1,64'd2,  2'd3, 32'd20,0, 32'd11,64'd2, 1);
    addVec("flush_20",         0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd20,1, 32'd11,64'd2, 0);
    addVec("bc_taken",         0,0,0, 6'd19, 24'd0,       14'h3FFF,  0,0, 5'b10000,0, 0,64'd0,  2'd3, 32'd20,0, 32'd11,64'd1, 1);
    addVec("bc_taken_flush",   0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd20,1, 32'd11,64'd1, 0);
    addVec("bc_not_taken",     0,0,0, 6'd19, 24'd0,       14'h3FFF,  0,0, 5'b10000,0, 0,64'd0,  2'd1, 32'd21,1, 32'd11,64'd0, 0);
    addVec("bc_ctr_wrap_lk",   0,0,0, 6'd19, 24'd0,       14'h3FFF,  0,1, 5'b10000,0, 0,64'd0,  2'd3, 32'd21,0, 32'd22,64'hFFFF_FFFF_FFFF_FFFF, 1);
    addVec("flush_ctr_ld",     0,0,0, 6'd18, 24'd9,       14'd0,     1,0, 5'b00000,0, 1,64'd5,  2'd1, 32'd21,1, 32'd22,64'd5, 0);
    addVec("bc_cond_fail",     0,0,0, 6'd19, 24'd0,       14'd0,     0,0, 5'b00100,1, 0,64'd0,  2'd1, 32'd22,1, 32'd22,64'd5, 0);
    addVec("bc_cond_abs",      0,0,0, 6'd19, 24'd0,       14'd40,    1,0, 5'b01100,1, 0,64'd0,  2'd3, 32'd40,0, 32'd22,64'd5, 1);
    addVec("bc_cond_flush",    0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd40,1, 32'd22,64'd5, 0);
    addVec("bc_ld_override",   0,0,0, 6'd19, 24'd0,       14'd3,     0,0, 5'b10010,0, 1,64'd1,  2'd1, 32'd41,1, 32'd22,64'd1, 0);
    addVec("bc_bo1_zero",      0,0,0, 6'd19, 24'd0,       14'd3,     0,0, 5'b10010,0, 0,64'd0,  2'd3, 32'd45,0, 32'd22,64'd0, 1);
    addVec("bc_bo1_flush",     0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd45,1, 32'd22,64'd0, 0);
    addVec("b_abs5",           0,0,0, 6'd18, 24'd5,       14'd0,     1,0, 5'b00000,0, 0,64'd0,  2'd3, 32'd5, 0, 32'd22,64'd0, 1);
    addVec("b_abs5_flush",     0,0,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd5, 1, 32'd22,64'd0, 0);
    addVec("stall1",           0,0,1, 6'd18, 24'd50,      14'd0,     1,1, 5'b00000,0, 0,64'd0,  2'd2, 32'd5, 0, 32'd22,64'd0, 0);
    addVec("stall2",           0,0,1, 6'd18, 24'd50,      14'd0,     1,1, 5'b00000,0, 0,64'd0,  2'd2, 32'd5, 0, 32'd22,64'd0, 0);
    addVec("stall3_ctr_ld",    0,0,1, 6'd18, 24'd50,      14'd0,     1,1, 5'b00000,0, 1,64'd7,  2'd2, 32'd5, 0, 32'd22,64'd7, 0);
    addVec("unstall",          0,0,0, 6'd18, 24'd50,      14'd0,     1,1, 5'b00000,0, 0,64'd0,  2'd1, 32'd5, 1, 32'd22,64'd7, 0);
    addVec("b_after_stall",    0,0,0, 6'd18, 24'd50,      14'd0,     1,1, 5'b00000,0, 0,64'd0,  2'd3, 32'd50,0, 32'd6, 64'd7, 1);
    addVec("reset_in_flush",   1,1,0, 6'd18, 24'd50,      14'd0,     1,1, 5'b00000,0, 1,64'd9,  2'd0, 32'd0, 0, 32'd0, 64'd0, 0);
    addVec("idle_stall",       0,0,1, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd0, 32'd0, 0, 32'd0, 64'd0, 0);
    addVec("start2",           0,1,0, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd1, 32'd0, 1, 32'd0, 64'd0, 0);
    addVec("stall_again",      0,0,1, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 0,64'd0,  2'd2, 32'd0, 0, 32'd0, 64'd0, 0);
    addVec("reset_in_stall",   1,0,1, 6'd0,  24'd0,       14'd0,     0,0, 5'b00000,0, 1,64'd3,  2'd0, 32'd0, 0, 32'd0, 64'd0, 0);

    reset8         = 1'b1;
    bus8.start     = 1'b0;
    bus8.stall     = 1'b0;
    bus8.opcode    = 6'd0;
    bus8.li        = '0;
    bus8.bd        = '0;
    bus8.aa        = 1'b0;
    bus8.lk        = 1'b0;
    bus8.bo        = '0;
    bus8.cond_true = 1'b0;
    bus8.ctr_load  = 1'b0;
    bus8.ctr_wdata = '0;

    // Main table: one vector per rising edge, outputs sampled 1 time unit later.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      #1;
      checkOutput({vecs[i].name, ".state"},    64'(bus.state),    64'(vecs[i].expState));
      checkOutput({vecs[i].name, ".pc"},       64'(bus.pc),       64'(vecs[i].expPc));
      checkOutput({vecs[i].name, ".pc_valid"}, 64'(bus.pc_valid), 64'(vecs[i].expValid));
      checkOutput({vecs[i].name, ".lr"},       64'(bus.lr),       64'(vecs[i].expLr));
      checkOutput({vecs[i].name, ".ctr"},      bus.ctr,           vecs[i].expCtr);
      checkOutput({vecs[i].name, ".redirect"}, 64'(bus.redirect), 64'(vecs[i].expRedirect));
    end

    // 8-bit address instance: absolute branch to -1 lands on 255, then wraps to 0.
    reset8 = 1'b1;
    @(posedge clock); #1;
    reset8 = 1'b0;
    bus8.start = 1'b1;
    @(posedge clock); #1;
    bus8.start = 1'b0;
    checkOutput("w8_start.pc", 64'(bus8.pc), 64'd0);
    bus8.opcode = 6'd18; bus8.aa = 1'b1; bus8.li = 24'hFFFFFF;
    @(posedge clock); #1;
    checkOutput("w8_abs_m1.pc", 64'(bus8.pc), 64'd255);
    checkOutput("w8_abs_m1.state", 64'(bus8.state), 64'd3);
    bus8.opcode = 6'd0; bus8.aa = 1'b0; bus8.li = '0;
    @(posedge clock); #1;
    checkOutput("w8_flush.pc", 64'(bus8.pc), 64'd255);
    checkOutput("w8_flush.pc_valid", 64'(bus8.pc_valid), 64'd1);
    @(posedge clock); #1;
    checkOutput("w8_wrap.pc", 64'(bus8.pc), 64'd0);
    bus8.opcode = 6'd18; bus8.aa = 1'b0; bus8.li = 24'hFFFFFE; bus8.lk = 1'b1;
    @(posedge clock); #1;
    checkOutput("w8_rel_m2.pc", 64'(bus8.pc), 64'd255);
    checkOutput("w8_rel_m2.lr", 64'(bus8.lr), 64'd1);
    bus8.opcode = 6'd0; bus8.lk = 1'b0; bus8.li = '0;
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
